// File: rtl/external_int_ctrl_prio.sv
// rtl/external_int_ctrl_prio.sv - prioritised external interrupt controller with claim/complete
// Build option: define EXT_INT_SYNC_EN to pass irq_source through a 2-flop synchronizer.

package external_int_ctrl_prio_pkg;
    typedef struct packed {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
    } sys_peripheral_t;

    typedef struct packed {
        logic wen;
        logic ren;
    } sel_t;
endpackage

module external_int_ctrl_prio
    import external_int_ctrl_prio_pkg::*;
#(
    parameter int INT_NUM   = 32,
    parameter int PRIO_BITS = 3
) (
    input  logic                hb_clk,
    input  logic                rst_sync_n,
    input  sys_peripheral_t     sys_share,
    input  sel_t                sel,
    output logic [31:0]         rdata,
    input  logic [INT_NUM-1:0]  irq_source,
    output logic [26:0]         custom_int_code,
    output logic                mextern_int
);

    localparam logic [7:0] OFF_ENABLE    = 8'h00;
    localparam logic [7:0] OFF_PENDING   = 8'h04;
    localparam logic [7:0] OFF_TRIGGER   = 8'h08;
    localparam logic [7:0] OFF_THRESHOLD = 8'h0C;
    localparam logic [7:0] OFF_CLAIM     = 8'h10;
    localparam logic [7:0] OFF_INSERVICE = 8'h14;

    logic [INT_NUM-1:0]   enable_q;
    logic [INT_NUM-1:0]   pending_q;
    logic [INT_NUM-1:0]   trigger_q;
    logic [INT_NUM-1:0]   inservice_q;
    logic [INT_NUM-1:0]   hist_q;
    logic                 hist_vld_q;
    logic [PRIO_BITS-1:0] threshold_q;
    logic [PRIO_BITS-1:0] prio_q [INT_NUM];

    logic [INT_NUM-1:0]   src;
    logic                 src_arm;
    logic [INT_NUM-1:0]   rise;
    logic [INT_NUM-1:0]   cand;
    logic [INT_NUM-1:0]   claim_vec;
    logic [INT_NUM-1:0]   cmp_vec;
    logic [INT_NUM-1:0]   pending_nxt;
    logic [INT_NUM-1:0]   inservice_nxt;
    logic [5:0]           best_id;
    logic [PRIO_BITS-1:0] best_prio;
    logic [31:0]          prio_word [4];
    logic [31:0]          rd_val;

    logic [7:0]           waddr_b;
    logic [7:0]           raddr_b;
    logic [31:0]          wdata;
    logic                 wr_enable;
    logic                 wr_pending;
    logic                 wr_trigger;
    logic                 wr_threshold;
    logic                 wr_complete;
    logic                 wr_prio;
    logic                 rd_claim;
    logic                 claim_fire;
    logic                 cmp_ok;
    logic                 unused_addr_bits;

    assign waddr_b = sys_share.waddr[7:0];
    assign raddr_b = sys_share.raddr[7:0];
    assign wdata   = sys_share.wdata;
    assign unused_addr_bits = ^{sys_share.waddr[31:8], sys_share.raddr[31:8]};

    assign wr_enable    = sel.wen && (waddr_b == OFF_ENABLE);
    assign wr_pending   = sel.wen && (waddr_b == OFF_PENDING);
    assign wr_trigger   = sel.wen && (waddr_b == OFF_TRIGGER);
    assign wr_threshold = sel.wen && (waddr_b == OFF_THRESHOLD);
    assign wr_complete  = sel.wen && (waddr_b == OFF_CLAIM);
    assign wr_prio      = sel.wen && (waddr_b[7:4] == 4'h2) && (waddr_b[1:0] == 2'b00);
    assign rd_claim     = sel.ren && (raddr_b == OFF_CLAIM);

`ifdef EXT_INT_SYNC_EN
    logic [INT_NUM-1:0] sync1_q;
    logic [INT_NUM-1:0] sync2_q;
    logic [1:0]         arm_q;

    // arm_q follows the synchronizer fill so edge history only counts once real samples arrive
    always_ff @(posedge hb_clk) begin
        if (!rst_sync_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            arm_q   <= '0;
        end else begin
            sync1_q <= irq_source;
            sync2_q <= sync1_q;
            arm_q   <= {arm_q[0], 1'b1};
        end
    end

    assign src     = sync2_q;
    assign src_arm = arm_q[1];
`else
    assign src     = irq_source;
    assign src_arm = 1'b1;
`endif

    // A source already high when history becomes valid is not an edge
    assign rise = src & ~hist_q & {INT_NUM{hist_vld_q}};

    always_comb begin
        cand = '0;
        for (int k = 0; k < INT_NUM; k++) begin
            cand[k] = pending_q[k] && !inservice_q[k] && (prio_q[k] > threshold_q);
        end
    end

    // Strict greater-than keeps the lowest index on equal priority
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int k = 0; k < INT_NUM; k++) begin
            if (cand[k] && (prio_q[k] > best_prio)) begin
                best_prio = prio_q[k];
                best_id   = 6'(k + 1);
            end
        end
    end

    assign claim_fire = rd_claim && (best_id != 6'd0);
    assign cmp_ok     = wr_complete && (wdata != 32'd0) && (wdata <= 32'(INT_NUM));

    always_comb begin
        claim_vec = '0;
        cmp_vec   = '0;
        for (int k = 0; k < INT_NUM; k++) begin
            claim_vec[k] = claim_fire && (best_id == 6'(k + 1));
            cmp_vec[k]   = cmp_ok && (wdata == 32'(k + 1));
        end
    end

    // A fresh edge beats every clear source on the same cycle
    always_comb begin
        pending_nxt = pending_q;
        for (int k = 0; k < INT_NUM; k++) begin
            if (!trigger_q[k]) begin
                pending_nxt[k] = src[k] && enable_q[k];
            end else if (rise[k] && enable_q[k]) begin
                pending_nxt[k] = 1'b1;
            end else if (!enable_q[k] || claim_vec[k] || (wr_pending && wdata[k])) begin
                pending_nxt[k] = 1'b0;
            end
        end
    end

    assign inservice_nxt = (inservice_q & ~cmp_vec) | claim_vec;

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            prio_word[w] = '0;
        end
        for (int k = 0; k < INT_NUM; k++) begin
            prio_word[k / 8][4 * (k % 8) +: PRIO_BITS] = prio_q[k];
        end
    end

    always_comb begin
        rd_val = '0;
        case (raddr_b)
            OFF_ENABLE:    rd_val = 32'(enable_q);
            OFF_PENDING:   rd_val = 32'(pending_q);
            OFF_TRIGGER:   rd_val = 32'(trigger_q);
            OFF_THRESHOLD: rd_val = 32'(threshold_q);
            OFF_CLAIM:     rd_val = 32'(best_id);
            OFF_INSERVICE: rd_val = 32'(inservice_q);
            8'h20, 8'h24, 8'h28, 8'h2C: rd_val = prio_word[raddr_b[3:2]];
            default:       rd_val = '0;
        endcase
    end

    always_ff @(posedge hb_clk) begin
        if (!rst_sync_n) begin
            enable_q        <= '0;
            pending_q       <= '0;
            trigger_q       <= '0;
            inservice_q     <= '0;
            hist_q          <= '0;
            hist_vld_q      <= 1'b0;
            threshold_q     <= '0;
            rdata           <= '0;
            mextern_int     <= 1'b0;
            custom_int_code <= '0;
            for (int k = 0; k < INT_NUM; k++) begin
                prio_q[k] <= '0;
            end
        end else begin
            hist_q      <= src;
            hist_vld_q  <= src_arm;
            pending_q   <= pending_nxt;
            inservice_q <= inservice_nxt;
            if (wr_enable) begin
                enable_q <= wdata[INT_NUM-1:0];
            end
            if (wr_trigger) begin
                trigger_q <= wdata[INT_NUM-1:0];
            end
            if (wr_threshold) begin
                threshold_q <= wdata[PRIO_BITS-1:0];
            end
            for (int k = 0; k < INT_NUM; k++) begin
                if (wr_prio && (waddr_b[3:2] == 2'(k / 8))) begin
                    prio_q[k] <= wdata[4 * (k % 8) +: PRIO_BITS];
                end
            end
            if (sel.ren) begin
                rdata <= rd_val;
            end
            mextern_int     <= |cand;
            custom_int_code <= {21'b0, best_id};
        end
    end

endmodule

// File: tb/tb_external_int_ctrl_prio.sv
// tb/tb_external_int_ctrl_prio.sv - scoreboard bench for external_int_ctrl_prio

module tb_external_int_ctrl_prio;
    import external_int_ctrl_prio_pkg::*;

`ifdef EXT_INT_SYNC_EN
    localparam int LAT      = 4;
    localparam int SYNC_DLY = 2;
`else
    localparam int LAT      = 2;
    localparam int SYNC_DLY = 0;
`endif

    localparam logic [7:0] ENA  = 8'h00;
    localparam logic [7:0] PEND = 8'h04;
    localparam logic [7:0] TRIG = 8'h08;
    localparam logic [7:0] THR  = 8'h0C;
    localparam logic [7:0] CLM  = 8'h10;
    localparam logic [7:0] INS  = 8'h14;
    localparam logic [7:0] PR0  = 8'h20;
    localparam logic [7:0] PR3  = 8'h2C;

    logic            hb_clk = 1'b0;
    logic            rst_sync_n = 1'b0;
    sys_peripheral_t sys_share = '0;
    sel_t            sel = '0;
    logic [31:0]     rdata;
    logic [31:0]     irq_source = '0;
    logic [26:0]     custom_int_code;
    logic            mextern_int;

    always #5 hb_clk = ~hb_clk;

    external_int_ctrl_prio #(.INT_NUM(32), .PRIO_BITS(3)) dut (
        .hb_clk          (hb_clk),
        .rst_sync_n      (rst_sync_n),
        .sys_share       (sys_share),
        .sel             (sel),
        .rdata           (rdata),
        .irq_source      (irq_source),
        .custom_int_code (custom_int_code),
        .mextern_int     (mextern_int)
    );

    logic [31:0] rd_exp_q [$];
    string       rd_name_q [$];
    logic [27:0] out_exp_q [$];
    string       out_name_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        rd_vld = 1'b0;
    logic        chk_out = 1'b0;

    always @(posedge hb_clk) rd_vld <= sel.ren;

    always @(negedge hb_clk) begin
        logic [31:0] e;
        logic [27:0] eo;
        string       nm;
        if (rd_vld) begin
            n_chk++;
            if (rd_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: rdata=%h with no queued expectation", rdata);
            end else begin
                e  = rd_exp_q.pop_front();
                nm = rd_name_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: rdata=%h expected %h", nm, rdata, e);
                end
            end
        end
        if (chk_out) begin
            n_chk++;
            if (out_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: no queued expectation");
            end else begin
                eo = out_exp_q.pop_front();
                nm = out_name_q.pop_front();
                if ({mextern_int, custom_int_code} !== eo) begin
                    n_fail++;
                    $display("FAIL %s: mextern_int=%b code=%0d expected mextern_int=%b code=%0d",
                             nm, mextern_int, custom_int_code, eo[27], eo[26:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge hb_clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        sys_share.waddr = 32'(a);
        sys_share.wdata = d;
        sel.wen = 1'b1;
        tick();
        sel.wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        sys_share.raddr = 32'(a);
        rd_exp_q.push_back(e);
        rd_name_q.push_back(nm);
        sel.ren = 1'b1;
        tick();
        sel.ren = 1'b0;
    endtask

    task automatic chk(input logic m, input logic [5:0] id, input string nm);
        out_exp_q.push_back({m, 21'b0, id});
        out_name_q.push_back(nm);
        chk_out = 1'b1;
        tick();
        chk_out = 1'b0;
    endtask

    task automatic do_reset();
        rst_sync_n = 1'b0;
        tick();
        tick();
        rst_sync_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        do_reset();
        chk(1'b0, 6'd0, "reset_out");
        rd(ENA, 32'h0, "reset_ena");
        rd(PR0, 32'h0, "reset_prio");

        // level source 3, priority 2
        wr(PR0, 32'h0000_2000);
        wr(ENA, 32'h0000_0008);
        irq_source[3] = 1'b1;
        tick();
        for (int i = 0; i < LAT - 1; i++) chk(1'b0, 6'd0, "lvl_lat_early");
        chk(1'b1, 6'd4, "lvl_lat");
        rd(CLM, 32'd4, "lvl_claim");
        chk(1'b1, 6'd4, "lvl_claim_same");
        chk(1'b0, 6'd0, "lvl_claim_next");
        rd(INS, 32'h8, "lvl_inservice");
        wr(CLM, 32'd4);
        chk(1'b0, 6'd0, "lvl_cmp_same");
        chk(1'b1, 6'd4, "lvl_cmp_next");
        irq_source = '0;

        // arbitration: 1 (prio 3), 5 and 6 (prio 5)
        do_reset();
        wr(PR0, 32'h0550_0030);
        wr(ENA, 32'h0000_0062);
        irq_source = 32'h0000_0062;
        repeat (SYNC_DLY + 2) tick();
        chk(1'b1, 6'd6, "arb_out");
        rd(CLM, 32'd6, "arb_claim_a");
        rd(CLM, 32'd7, "arb_claim_b");
        rd(CLM, 32'd2, "arb_claim_c");
        rd(CLM, 32'd0, "arb_claim_none");
        rd(INS, 32'h62, "arb_inservice");
        chk(1'b0, 6'd0, "arb_all_served");
        rd(PR0, 32'h0550_0030, "prio_rb");
        wr(CLM, 32'd6);
        wr(CLM, 32'd7);
        wr(CLM, 32'd2);
        wr(THR, 32'd5);
        tick();
        chk(1'b0, 6'd0, "thr5_block");
        wr(THR, 32'd4);
        tick();
        chk(1'b1, 6'd6, "thr4_pass");
        rd(THR, 32'd4, "thr_rb");
        wr(PR3, 32'hFFFF_FFFF);
        rd(PR3, 32'h7777_7777, "prio_mask");
        wr(8'h18, 32'hFFFF_FFFF);
        rd(8'h18, 32'h0, "unmapped");
        rd(ENA, 32'h62, "ena_rb");
        irq_source = '0;

        // edge source 0
        do_reset();
        wr(TRIG, 32'h1);
        wr(PR0, 32'h1);
        wr(ENA, 32'h1);
        irq_source[0] = 1'b1;
        tick();
        irq_source[0] = 1'b0;
        repeat (SYNC_DLY + 1) tick();
        rd(PEND, 32'h1, "edge_pend");
        chk(1'b1, 6'd1, "edge_out");
        rd(CLM, 32'd1, "edge_claim");
        rd(PEND, 32'h0, "edge_pend_clr");
        rd(INS, 32'h1, "edge_ins");
        irq_source[0] = 1'b1;
        tick();
        irq_source[0] = 1'b0;
        repeat (SYNC_DLY) tick();
        rd(PEND, 32'h1, "edge_repend");
        rd(CLM, 32'd0, "edge_blocked");
        chk(1'b0, 6'd0, "edge_blocked_out");
        wr(CLM, 32'd1);
        tick();
        chk(1'b1, 6'd1, "edge_cmp_out");
        rd(CLM, 32'd1, "edge_reclaim");

        // new edge on the same cycle as W1C of that bit
        do_reset();
        wr(TRIG, 32'h4);
        wr(ENA, 32'h4);
        irq_source[2] = 1'b1;
        tick();
        irq_source[2] = 1'b0;
        repeat (SYNC_DLY + 1) tick();
        rd(PEND, 32'h4, "col_pre");
        irq_source[2] = 1'b1;
        repeat (SYNC_DLY) tick();
        wr(PEND, 32'h4);
        irq_source[2] = 1'b0;
        rd(PEND, 32'h4, "col_hold");
        repeat (SYNC_DLY) tick();
        wr(PEND, 32'h4);
        rd(PEND, 32'h0, "w1c_clr");

        // invalid completes, then reset mid-operation
        do_reset();
        wr(TRIG, 32'h1);
        wr(PR0, 32'h0000_2001);
        wr(ENA, 32'h9);
        irq_source[3] = 1'b1;
        irq_source[0] = 1'b1;
        tick();
        irq_source[0] = 1'b0;
        repeat (SYNC_DLY + 1) tick();
        rd(CLM, 32'd4, "inv_claim");
        wr(CLM, 32'd0);
        wr(CLM, 32'd40);
        rd(INS, 32'h8, "inv_ins");
        rd(PEND, 32'h9, "inv_pend");
        chk(1'b1, 6'd1, "inv_out");
        irq_source[0] = 1'b1;
        repeat (SYNC_DLY + 1) tick();
        rst_sync_n = 1'b0;
        tick();
        rst_sync_n = 1'b1;
        chk(1'b0, 6'd0, "rst_out");
        rd(ENA, 32'h0, "rst_ena");
        rd(PEND, 32'h0, "rst_pend");
        rd(TRIG, 32'h0, "rst_trig");
        rd(THR, 32'h0, "rst_thr");
        rd(INS, 32'h0, "rst_ins");
        rd(PR0, 32'h0, "rst_prio");
        rd(CLM, 32'h0, "rst_claim");
        wr(TRIG, 32'h1);
        wr(PR0, 32'h1);
        wr(ENA, 32'h1);
        repeat (SYNC_DLY + 1) tick();
        rd(PEND, 32'h0, "held_no_edge");
        chk(1'b0, 6'd0, "held_out");
        irq_source[0] = 1'b0;
        repeat (SYNC_DLY + 2) tick();
        irq_source[0] = 1'b1;
        repeat (SYNC_DLY + 1) tick();
        rd(PEND, 32'h1, "held_toggle");

        repeat (3) tick();
        if (rd_exp_q.size() != 0 || out_exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL leftover: %0d read and %0d output expectations never checked",
                     rd_exp_q.size(), out_exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
